ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes the operands and destination register delivered by the ID/EX pipeline register and computes one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU per request using a radix-2 shift-add / restoring-division datapath. It stalls the front of the pipeline while busy and presents a result to the EX/MEM boundary in the cycle that stall drops.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/ex_muldiv_unit_if.sv | 22 ++
 rtl/muldiv_datapath.sv | 83 ++++++++
 rtl/ex_muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types, constants and sign helper for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    function automatic logic [31:0] neg_if(input logic [31:0] value, input logic cond);
        if (cond) begin
            return ~value + 32'd1;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX request and EX/MEM result bundle of the multiply/divide unit.
interface ex_muldiv_unit_if;
    logic        start_e;
    logic [2:0]  op_e;
    logic [31:0] rs1_val_e;
    logic [31:0] rs2_val_e;
    logic [4:0]  rd_e;
    logic        stall_req;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    modport master (
        output start_e, op_e, rs1_val_e, rs2_val_e, rd_e,
        input  stall_req, done, result, rd_out
    );

    modport slave (
        input  start_e, op_e, rs1_val_e, rs2_val_e, rd_e,
        output stall_req, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiply / restoring divide registers around one shared 33-bit adder.
// hi holds the partial product high word or the partial remainder; lo holds multiplier/quotient bits.
module muldiv_datapath (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] load_hi,
    input  logic [31:0] load_lo,
    input  logic [31:0] load_b,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    logic [31:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [32:0] add_a_s, add_b_s, sum_s;
    logic        add_cin_s;

    // Shared adder: multiply accumulates, divide performs the trial subtract via ~b + 1.
    always_comb begin
        if (is_div) begin
            add_a_s   = {hi_q, lo_q[31]};
            add_b_s   = ~{1'b0, b_q};
            add_cin_s = 1'b1;
        end else begin
            add_a_s   = {1'b0, hi_q};
            add_b_s   = {1'b0, b_q};
            add_cin_s = 1'b0;
        end
        sum_s = add_a_s + add_b_s + {32'd0, add_cin_s};
    end

    // Next-state of the iteration registers.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        b_d  = b_q;
        if (clear) begin
            hi_d = 32'd0;
            lo_d = 32'd0;
            b_d  = 32'd0;
        end else if (load) begin
            hi_d = load_hi;
            lo_d = load_lo;
            b_d  = load_b;
        end else if (step) begin
            if (is_div) begin
                // A clear sign bit means the trial subtract did not underflow.
                lo_d = {lo_q[30:0], ~sum_s[32]};
                if (sum_s[32]) begin
                    hi_d = add_a_s[31:0];
                end else begin
                    hi_d = sum_s[31:0];
                end
            end else if (lo_q[0]) begin
                hi_d = sum_s[32:1];
                lo_d = {sum_s[0], lo_q[31:1]};
            end else begin
                hi_d = {1'b0, hi_q[31:1]};
                lo_d = {hi_q[0], lo_q[31:1]};
            end
        end else begin
            hi_d = hi_q;
        end
    end

    // Iteration register bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
            b_q  <= 32'd0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M unit: issue/iterate/done FSM, pipeline stall, operand and result sign handling.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    ex_muldiv_unit_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]      state_q, state_d;
    logic [4:0]      count_q, count_d, rd_q, rd_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d, sign_a_q, sign_a_d, special_q, special_d;
    logic            a_signed_s, b_signed_s, sign_a_s, sign_b_s, div_zero_s, ovf_s;
    logic            load_s, step_s;
    logic [XLEN-1:0] a_mag_s, b_mag_s, load_hi_s, load_lo_s, hi_s, lo_s;
    logic [XLEN-1:0] prod_hi_s, prod_lo_s, quo_s, rem_s, sel_s, result_s;

    // Operand signedness, magnitudes and fast-path detection for the presented instruction.
    always_comb begin
        a_signed_s = (bus.op_e == OP_MUL) || (bus.op_e == OP_MULH) || (bus.op_e == OP_MULHSU)
                  || (bus.op_e == OP_DIV) || (bus.op_e == OP_REM);
        b_signed_s = (bus.op_e == OP_MUL) || (bus.op_e == OP_MULH)
                  || (bus.op_e == OP_DIV) || (bus.op_e == OP_REM);
        sign_a_s   = a_signed_s & bus.rs1_val_e[31];
        sign_b_s   = b_signed_s & bus.rs2_val_e[31];
        a_mag_s    = neg_if(bus.rs1_val_e, sign_a_s);
        b_mag_s    = neg_if(bus.rs2_val_e, sign_b_s);
        div_zero_s = bus.op_e[2] & (bus.rs2_val_e == 32'd0);
        ovf_s      = bus.op_e[2] & ~bus.op_e[0] & (bus.rs1_val_e == INT_MIN)
                   & (bus.rs2_val_e == 32'hFFFF_FFFF);
    end

    // Control FSM; flush aborts from any state and outranks a new request.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        rd_d      = rd_q;
        neg_d     = neg_q;
        sign_a_d  = sign_a_q;
        special_d = special_q;
        load_s    = 1'b0;
        step_s    = 1'b0;
        load_hi_s = 32'd0;
        load_lo_s = a_mag_s;
        if (flush) begin
            state_d = ST_IDLE;
            count_d = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_e) begin
                        load_s    = 1'b1;
                        op_d      = bus.op_e;
                        rd_d      = bus.rd_e;
                        neg_d     = sign_a_s ^ sign_b_s;
                        sign_a_d  = sign_a_s;
                        count_d   = 5'd0;
                        special_d = div_zero_s | ovf_s;
                        if (div_zero_s) begin
                            load_hi_s = bus.rs1_val_e;
                            load_lo_s = DIV_BY_ZERO_Q;
                            state_d   = ST_DONE;
                        end else if (ovf_s) begin
                            load_hi_s = 32'd0;
                            load_lo_s = INT_MIN;
                            state_d   = ST_DONE;
                        end else begin
                            state_d   = ST_CALC;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    step_s = 1'b1;
                    if (count_q == 5'd31) begin
                        state_d = ST_DONE;
                        count_d = 5'd0;
                    end else begin
                        count_d = count_q + 5'd1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and captured-instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= 5'd0;
            op_q      <= 3'd0;
            rd_q      <= 5'd0;
            neg_q     <= 1'b0;
            sign_a_q  <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            neg_q     <= neg_d;
            sign_a_q  <= sign_a_d;
            special_q <= special_d;
        end
    end

    muldiv_datapath u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .load    (load_s),
        .step    (step_s),
        .is_div  (op_q[2]),
        .load_hi (load_hi_s),
        .load_lo (load_lo_s),
        .load_b  (b_mag_s),
        .hi      (hi_s),
        .lo      (lo_s)
    );

    // Sign correction and result select; fast-path results are already final.
    always_comb begin
        prod_lo_s = neg_if(lo_s, neg_q);
        // The high word only takes the +1 of the 64-bit negate when the low word is zero.
        if (neg_q && (lo_s != 32'd0)) begin
            prod_hi_s = ~hi_s;
        end else begin
            prod_hi_s = neg_if(hi_s, neg_q);
        end
        quo_s = neg_if(lo_s, neg_q & ~special_q);
        rem_s = neg_if(hi_s, sign_a_q & ~special_q);
        case (op_q)
            OP_MUL:                       sel_s = prod_lo_s;
            OP_MULH, OP_MULHSU, OP_MULHU: sel_s = prod_hi_s;
            OP_DIV, OP_DIVU:              sel_s = quo_s;
            OP_REM, OP_REMU:              sel_s = rem_s;
            default:                      sel_s = 32'd0;
        endcase
        if (state_q == ST_DONE) begin
            result_s = sel_s;
        end else begin
            result_s = 32'd0;
        end
    end

    assign bus.stall_req = ((state_q == ST_IDLE) & bus.start_e & ~flush) | (state_q == ST_CALC);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.result    = result_s;
    assign bus.rd_out    = (state_q == ST_DONE) ? rd_q : 5'd0;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: vector table plus flush/reset/hold sequences.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;
    vec_t vecs [19];

    ex_muldiv_unit_if bus_if ();

    ex_muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_stall"},  {31'd0, bus_if.stall_req}, 32'd0);
        chk({tag, "_done"},   {31'd0, bus_if.done},      32'd0);
        chk({tag, "_result"}, bus_if.result,             32'd0);
        chk({tag, "_rd_out"}, {27'd0, bus_if.rd_out},    32'd0);
    endtask

    task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
        bus_if.start_e   = 1'b1;
        bus_if.op_e      = op;
        bus_if.rs1_val_e = a;
        bus_if.rs2_val_e = b;
        bus_if.rd_e      = rd;
    endtask

    // Issue one request (called #1 after a rising edge) with start held through DONE.
    task automatic run_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expv, input int exp_lat, input logic [4:0] rd);
        int lat;
        int stall_cnt;
        present(op, a, b, rd);
        #1;
        stall_cnt = bus_if.stall_req ? 1 : 0;
        @(posedge clk); #1;
        lat = 0;
        while (!bus_if.done && lat < 40) begin
            if (bus_if.stall_req) stall_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("result", bus_if.result, expv);
        chk("rd_out", {27'd0, bus_if.rd_out}, {27'd0, rd});
        chk("stall_cycles", stall_cnt, exp_lat + 1);
        chk("stall_in_done", {31'd0, bus_if.stall_req}, 32'd0);
        @(posedge clk); #1;
        chk("single_pulse", {31'd0, bus_if.done}, 32'd0);
        bus_if.start_e = 1'b0;
    endtask

    initial begin
        int n;
        clk = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        checks = 0;
        errors = 0;
        bus_if.start_e = 1'b0;
        bus_if.op_e = 3'd0;
        bus_if.rs1_val_e = 32'd0;
        bus_if.rs2_val_e = 32'd0;
        bus_if.rd_e = 5'd0;

        vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32};
        vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
        vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD, 32};
        vecs[5]  = '{OP_REM,    32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFE, 32};
        vecs[6]  = '{OP_DIVU,   32'h0000_0014, 32'h0000_0006, 32'h0000_0003, 32};
        vecs[7]  = '{OP_REMU,   32'h0000_0014, 32'h0000_0006, 32'h0000_0002, 32};
        vecs[8]  = '{OP_DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0};
        vecs[9]  = '{OP_REM,    32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0};
        vecs[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
        vecs[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};
        vecs[12] = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 0};
        vecs[13] = '{OP_DIVU,   32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0};
        vecs[14] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32};
        vecs[15] = '{OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32};
        vecs[16] = '{OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32};
        vecs[17] = '{OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32};
        vecs[18] = '{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32};

        #12;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_idle_outputs("idle");

        // Table vectors issued back to back.
        for (int i = 0; i < 19; i++) begin
            run_vec(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 5'(i + 1));
        end

        // Flush after ten iterations: no done, stall released.
        present(OP_DIV, 32'h0000_0064, 32'h0000_0007, 5'd9);
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        bus_if.start_e = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_stall", {31'd0, bus_if.stall_req}, 32'd0);
        chk("flush_done", {31'd0, bus_if.done}, 32'd0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus_if.done) n++;
        end
        chk("flush_no_done", n, 0);
        run_vec(OP_MUL, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 32, 5'd3);

        // Asynchronous reset at iteration twenty.
        present(OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0003, 5'd17);
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus_if.start_e = 1'b0;
        #1;
        chk_idle_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus_if.done || bus_if.stall_req) n++;
        end
        chk("reset_no_resume", n, 0);
        run_vec(OP_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32, 5'd31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
